// File: rtl/mutative_data_array_ctrl.sv
// Initiator-side controller for the single-port 128 x 256-bit mutative cache
// data array. It maps a valid/ready request stream onto the SRAM's active-low
// port pins, then returns read data in issue order through a 2-entry response
// FIFO. The SRAM port is driven combinationally from the request, so an
// accepted request reaches the macro at the same edge that accepts it.
module mutative_data_array_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic [1:0]            occ;
  logic                  rd_inflight;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic [1:0]            committed;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Entries already held plus the one reserved for a read still in the SRAM.
  assign committed  = occ + {1'b0, rd_inflight};
  assign resp_valid = (occ != 2'd0);
  assign pop        = resp_valid && resp_ready;
  assign push       = rd_inflight;

  // A pop in this cycle frees a slot at the same edge, which keeps a full
  // FIFO streaming at one request per cycle.
  assign req_ready = rst_n && ((committed < 2'd2) || pop);
  assign accept    = req_valid && req_ready && rst_n;

  assign sram_csb0   = !accept;
  assign sram_web0   = !(accept && req_write);
  assign sram_wmask0 = (accept && req_write) ? req_wmask : '0;
  assign sram_addr0  = req_addr;
  assign sram_din0   = req_wdata;

  assign resp_rdata = fifo_mem[rd_ptr];

  // Track the outstanding read and maintain FIFO occupancy and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      rd_inflight <= accept && !req_write;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Capture the SRAM output one cycle after a read was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_mutative_data_array_ctrl.sv
// Self-checking bench for mutative_data_array_ctrl: a behavioural SRAM, a
// queue-based reference model checked every cycle, a directed vector table,
// hand-written multi-cycle sequences and a randomized phase.
module tb_mutative_data_array_ctrl;

  localparam int AW = 7;
  localparam int DW = 256;
  localparam int NM = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NM-1:0] req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mutative_data_array_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_WMASKS(NM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: registers its port when chip select is low.
  logic [DW-1:0] sram_mem [128];
  logic [DW-1:0] sram_bitmask;

  always_comb begin
    sram_bitmask = '0;
    for (int i = 0; i < DW; i++) sram_bitmask[i] = sram_wmask0[i / 8];
  end

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0)
        sram_mem[sram_addr0] <= (sram_mem[sram_addr0] & ~sram_bitmask) | (sram_din0 & sram_bitmask);
      else
        sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [NM-1:0] m, input bit rr);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wmask  = m;
    resp_ready = rr;
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // Reference model: ordered queue of responses owed, plus the read in the array.
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] resp_q [$];
  bit            inflight = 1'b0;
  logic [DW-1:0] inflight_data;
  int            reads_owed = 0;
  int            resps_seen = 0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
  end

  // Check every DUT output mid-cycle and advance the model to the next edge.
  always @(negedge clk) begin
    bit exp_valid, exp_ready, exp_acc;
    if (!rst_n) begin
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_rdata", resp_rdata, 0);
      checkOutput("rst_csb0", sram_csb0, 1);
      checkOutput("rst_web0", sram_web0, 1);
      checkOutput("rst_wmask0", sram_wmask0, 0);
      reads_owed -= resp_q.size() + (inflight ? 1 : 0);
      resp_q.delete();
      inflight = 1'b0;
    end else begin
      exp_valid = resp_q.size() != 0;
      exp_ready = (resp_q.size() + (inflight ? 1 : 0) < 2) || (exp_valid && resp_ready);
      exp_acc   = req_valid && exp_ready;
      checkOutput("m_req_ready", req_ready, exp_ready);
      checkOutput("m_resp_valid", resp_valid, exp_valid);
      if (exp_valid) checkOutput("m_resp_rdata", resp_rdata, resp_q[0]);
      checkOutput("m_csb0", sram_csb0, !exp_acc);
      checkOutput("m_web0", sram_web0, !(exp_acc && req_write));
      checkOutput("m_wmask0", sram_wmask0, (exp_acc && req_write) ? req_wmask : '0);
      if (exp_acc) begin
        checkOutput("m_addr0", sram_addr0, req_addr);
        checkOutput("m_din0", sram_din0, req_wdata);
      end
      if (resp_valid && resp_ready) resps_seen++;
      if (exp_valid && resp_ready) void'(resp_q.pop_front());
      if (inflight) resp_q.push_back(inflight_data);
      inflight = exp_acc && !req_write;
      if (exp_acc && !req_write) begin
        inflight_data = ref_mem[req_addr];
        reads_owed++;
      end
      if (exp_acc && req_write)
        for (int b = 0; b < NM; b++)
          if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    bit            is_write;
    logic [AW-1:0] addr;
    logic [7:0]    fill;
    logic [NM-1:0] wmask;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs [7];
  logic [DW-1:0] line_data [8];
  logic [DW-1:0] saved;

  initial begin
    int first, last, cnt;
    bit got;

    vecs[0] = '{1'b1, 7'h05, 8'hA5, 32'hFFFF_FFFF, '0};
    vecs[1] = '{1'b0, 7'h05, 8'h00, 32'h0000_0000, {32{8'hA5}}};
    vecs[2] = '{1'b1, 7'h10, 8'h00, 32'hFFFF_FFFF, '0};
    vecs[3] = '{1'b1, 7'h10, 8'hFF, 32'h0000_0001, '0};
    vecs[4] = '{1'b0, 7'h10, 8'h00, 32'h0000_0000, 256'hFF};
    vecs[5] = '{1'b1, 7'h7F, 8'h3C, 32'hFFFF_FFFF, '0};
    vecs[6] = '{1'b0, 7'h7F, 8'h00, 32'h0000_0000, {32{8'h3C}}};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: back-to-back ops, each read answered two samples later.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i < 7) applyStimulus(1'b1, vecs[i].is_write, vecs[i].addr, rep(vecs[i].fill), vecs[i].wmask, 1'b1);
      else       applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
      @(negedge clk);
      if (i < 7) begin
        checkOutput("tbl_ready", req_ready, 1);
        checkOutput("tbl_csb0", sram_csb0, 0);
        checkOutput("tbl_web0", sram_web0, !vecs[i].is_write);
        checkOutput("tbl_wmask0", sram_wmask0, vecs[i].is_write ? vecs[i].wmask : '0);
      end
      if (i >= 2 && !vecs[i-2].is_write) begin
        checkOutput("tbl_resp_valid", resp_valid, 1);
        checkOutput("tbl_resp_rdata", resp_rdata, vecs[i-2].exp_rdata);
      end
    end

    // Prefill lines 0..7, then stream 8 reads back to back.
    for (int k = 0; k < 8; k++) begin
      line_data[k] = rand_line();
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, AW'(k), line_data[k], '1, 1'b1);
    end
    first = -1; last = -1; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k < 8) applyStimulus(1'b1, 1'b0, AW'(k), '0, '0, 1'b1);
      else       applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
      @(negedge clk);
      if (k < 8) checkOutput("stream_ready", req_ready, 1);
      if (resp_valid) begin
        if (first < 0) first = k;
        last = k;
        if (cnt < 8) checkOutput("stream_rdata", resp_rdata, line_data[cnt]);
        cnt++;
      end
    end
    checkOutput("stream_count", cnt, 8);
    checkOutput("stream_first", first, 2);
    checkOutput("stream_last", last, 9);

    // Backpressure: three reads against a stalled consumer.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 4)       applyStimulus(1'b1, 1'b0, AW'(k < 2 ? k : 2), '0, '0, 1'b0);
      else if (k == 4) applyStimulus(1'b1, 1'b0, 7'd2, '0, '0, 1'b1);
      else             applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
      @(negedge clk);
      if (k == 2 || k == 3) begin
        checkOutput("bp_stall_ready", req_ready, 0);
        checkOutput("bp_stall_csb0", sram_csb0, 1);
      end
      if (k == 4) begin
        checkOutput("bp_release_ready", req_ready, 1);
        checkOutput("bp_release_csb0", sram_csb0, 0);
      end
      if (k >= 4 && k <= 6) checkOutput("bp_order", resp_rdata, line_data[k-4]);
      if (k == 7) checkOutput("bp_drained", resp_valid, 0);
    end

    // Reset with a read in flight; a gated write is attempted during reset.
    saved = rand_line();
    @(posedge clk); #1 applyStimulus(1'b1, 1'b1, 7'h20, saved, '1, 1'b1);
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 7'h20, '0, '0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 7'h20, '0, '1, 1'b1);
    @(negedge clk);
    checkOutput("rstmid_csb0", sram_csb0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstmid_no_stale", resp_valid, 0);
    end
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 7'h20, '0, '0, 1'b1);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    got = 1'b0;
    for (int t = 0; t < 5 && !got; t++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        checkOutput("rstmid_readback", resp_rdata, saved);
      end
    end
    checkOutput("rstmid_readback_seen", got, 1);

    // Randomized traffic over a small address window.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, AW'($urandom_range(0, 15)),
                    rand_line(), NM'($urandom()), $urandom_range(0, 9) < 6);
    end

    // Drain and confirm every accepted read was answered exactly once.
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("drain_resp_valid", resp_valid, 0);
    checkOutput("drain_resp_count", resps_seen, reads_owed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
